rf_write_scheduler: RTL and testbench
=====================================

# rf_write_scheduler

Write-port scheduler for the 32x32 MIPS register file in the pipelined datapath. It shares the register file's single write port between the pipeline writeback stage and a multi-cycle multiply/divide unit (MDU). Writeback has fixed priority, and a starvation guard periodically freezes writeback so the MDU can retire. A 32-bit scoreboard tracks registers with an outstanding MDU result and flags read hazards to decode.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive denied MDU cycles before a forced MDU grant; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- wb_we  in  1  writeback write request from the pipeline.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- mdu_issue  in  1  decode issues an MDU op this cycle.
- mdu_issue_addr  in  5  destination register of the issued MDU op.
- mdu_valid  in  1  MDU result pending; held until mdu_ready.
- mdu_addr  in  5  MDU result destination.
- mdu_data  in  32  MDU result data.
- mdu_ready  out  1  combinational; MDU result accepted this cycle.
- rd_addr1, rd_addr2  in  5 each  decode read addresses.
- hazard  out  1  combinational; decode must stall.
- wb_stall  out  1  writeback slot taken this cycle; pipeline must freeze WB and re-present it next cycle.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  5  register file write address (registered).
- rf_wdata  out  32  register file write data (registered).
- busy  out  32  scoreboard; bit i set means register i awaits an MDU result.

## Operation
- **Effective WB request:** wb_req = wb_we && wb_addr != 0.
- **FSM states:**
  - IDLE: no denied MDU request.
  - WAIT: MDU request denied; cnt counts denied cycles.
  - FORCE: MDU granted unconditionally.
- **Grant rule, per cycle:**
  - FORCE: grant MDU and ignore wb_we.
  - Otherwise, if wb_req: grant WB.
  - Otherwise, if mdu_valid: grant MDU.
- mdu_ready = MDU granted. This holds even for mdu_addr == 0: the handshake completes and no write occurs.
- **Transitions:**
  - IDLE -> WAIT when mdu_valid is denied; cnt = 1.
  - WAIT, denied: cnt++. If cnt reaches STARVE_LIMIT, go to FORCE.
  - WAIT, granted: -> IDLE, cnt = 0.
  - WAIT with mdu_valid low (protocol violation): -> IDLE, cnt = 0.
  - FORCE -> IDLE after exactly one cycle.
- wb_stall = (state == FORCE).
- **Write port:** registered copy of the granted request. rf_we = 1 only if the granted address != 0. With no grant, rf_we = 0 and rf_waddr/rf_wdata hold their previous values. An internal flag records whether the registered write is an MDU write.
- **Scoreboard:**
  - Set busy[mdu_issue_addr] on mdu_issue when the address != 0.
  - Clear busy[rf_waddr] at the edge where a registered MDU write is on the port (rf_we = 1 with the MDU flag).
  - Set and clear of the same bit at the same edge: set wins.
  - busy[0] is always 0.
- hazard = (rd_addr1 != 0 && busy[rd_addr1]) || (rd_addr2 != 0 && busy[rd_addr2]).

## Timing
- **Reset:**
  - State: IDLE, cnt = 0, busy = 0.
  - Outputs: rf_we = 0, rf_waddr = 0, rf_wdata = 0, wb_stall = 0.
  - mdu_ready and hazard are forced to 0 while rst is high.
  - rst asserted mid-FORCE or mid-WAIT aborts immediately; a pending MDU result re-arbitrates from IDLE after release.
- **Write latency:** grant in cycle N gives rf_we/addr/data valid in cycle N+1; the register file captures at the end of N+1.
- **Busy timing:**
  - An MDU write granted in N clears busy at the end of N+1, so hazard drops in N+2.
  - mdu_issue in N makes busy and hazard visible from N+1.
- **Worst-case MDU wait:** STARVE_LIMIT denied cycles, then one FORCE cycle. With STARVE_LIMIT = 4 the MDU is granted in the 5th cycle of continuous wb_req.
- **WB hold contract:** the pipeline holds WB contents stable across a wb_stall cycle; the held write is granted in the following cycle.

## Test plan
- **WB only:** wb_we = 1, wb_addr = 7, wb_data = 0xDEADBEEF in cycle N -> next cycle rf_we = 1, rf_waddr = 7, rf_wdata = 0xDEADBEEF; wb_stall = 0 throughout.
- **Starvation guard:** STARVE_LIMIT = 4, wb_req every cycle, mdu_valid = 1 with mdu_addr = 9, mdu_data = 0x1234 from cycle 0 -> WB granted cycles 0-3, wb_stall = 1 and mdu_ready = 1 in cycle 4, rf_waddr = 9 with 0x1234 in cycle 5, held WB written in cycle 6.
- **Scoreboard:** mdu_issue addr 5 in cycle 0 -> hazard = 1 for rd_addr1 = 5 from cycle 1. MDU granted in cycle 3 -> busy[5] = 0 and hazard = 0 from cycle 5.
- **Zero register:** wb_we = 1 with addr 0 and mdu_valid = 1 in the same cycle -> MDU granted; mdu_issue to addr 0 -> busy stays 0; hazard = 0 for rd_addr1 = 0.
- **Set beats clear:** MDU write to reg 3 on the port while mdu_issue addr 3 arrives at the same edge -> busy[3] = 1 afterwards.
- **Reset mid-operation:** rst asserted in the FORCE cycle -> wb_stall, rf_we, busy and mdu_ready are 0 immediately. After release with mdu_valid still high and no wb_req -> MDU granted in the first cycle.

Source files
------------

// File: rtl/rf_write_scheduler.sv
// Shares the register-file write port between pipeline writeback and the MDU,
// with a starvation guard for the MDU and a scoreboard of pending MDU results.
module rf_write_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_addr,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic        hazard,
    output logic        wb_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy
);

    localparam int DATA_W = 32;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt, cnt_inc;
    logic        wb_req;
    logic        grant_wb, grant_mdu;
    logic [4:0]  gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic        rf_mdu_p1;
    logic [31:0] busy_nxt;

    assign wb_req  = wb_we && (wb_addr != 5'd0);
    assign cnt_inc = cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        grant_wb  = 1'b0;
        grant_mdu = 1'b0;
        case (state)
            FORCE: begin
                grant_mdu = mdu_valid;
            end
            default: begin
                grant_wb  = wb_req;
                grant_mdu = mdu_valid && !wb_req;
                // A denied MDU request counts toward the forced grant
                if (mdu_valid && wb_req) begin
                    if (cnt_inc >= LIMIT) begin
                        state_nxt = FORCE;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = cnt_inc;
                    end
                end
            end
        endcase
    end

    assign wb_stall  = (state == FORCE);
    assign mdu_ready = grant_mdu && !rst;
    assign gnt_addr  = grant_mdu ? mdu_addr : wb_addr;
    assign gnt_data  = grant_mdu ? mdu_data : wb_data;

    // Write port stage: registered copy of the granted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= '0;
            rf_mdu_p1 <= 1'b0;
        end else begin
            rf_we <= (grant_wb || grant_mdu) && (gnt_addr != 5'd0);
            if (grant_wb || grant_mdu) begin
                rf_waddr  <= gnt_addr;
                rf_wdata  <= gnt_data;
                rf_mdu_p1 <= grant_mdu;
            end
        end
    end

    // Clear first so a same-edge issue to the same register wins
    always_comb begin
        busy_nxt = busy;
        if (rf_we && rf_mdu_p1)
            busy_nxt[rf_waddr] = 1'b0;
        if (mdu_issue && (mdu_issue_addr != 5'd0))
            busy_nxt[mdu_issue_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign hazard = !rst &&
                    (((rd_addr1 != 5'd0) && busy[rd_addr1]) ||
                     ((rd_addr2 != 5'd0) && busy[rd_addr2]));

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: WB path, starvation guard, scoreboard,
// zero register, set-beats-clear and reset during FORCE.
module tb_rf_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        hazard, wb_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, busy;

    int vectors = 0;
    int miscompares = 0;

    rf_write_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .hazard(hazard), .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    initial begin
        rst = 1'b1;
        wb_we = 0; wb_addr = 0; wb_data = 0;
        mdu_issue = 0; mdu_issue_addr = 0;
        mdu_valid = 1; mdu_addr = 5'd4; mdu_data = 32'h44;
        rd_addr1 = 0; rd_addr2 = 0;
        tick; tick;
        settle;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_wb_stall", wb_stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mdu_ready", mdu_ready, 0);
        mdu_valid = 0;
        tick;
        rst = 1'b0;

        // WB only
        wb_we = 1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
        settle;
        chk("wb_stall_wb", wb_stall, 0);
        tick;
        wb_we = 0;
        chk("wb_rf_we", rf_we, 1);
        chk("wb_waddr", rf_waddr, 7);
        chk("wb_wdata", rf_wdata, 32'hDEADBEEF);
        tick;
        chk("idle_rf_we", rf_we, 0);
        chk("idle_hold_waddr", rf_waddr, 7);
        chk("idle_hold_wdata", rf_wdata, 32'hDEADBEEF);

        // Starvation guard: WB every cycle, MDU pending from cycle 0
        mdu_valid = 1; mdu_addr = 5'd9; mdu_data = 32'h1234;
        wb_we = 1; wb_addr = 5'd10;
        for (int i = 0; i < 4; i++) begin
            wb_data = 32'hA0 + i;
            settle;
            chk("starve_ready", mdu_ready, 0);
            chk("starve_stall", wb_stall, 0);
            tick;
            chk("starve_wb_addr", rf_waddr, 10);
            chk("starve_wb_data", rf_wdata, 32'hA0 + i);
        end
        wb_data = 32'hA4;
        settle;
        chk("force_stall", wb_stall, 1);
        chk("force_ready", mdu_ready, 1);
        tick;
        mdu_valid = 0;
        chk("force_rf_we", rf_we, 1);
        chk("force_waddr", rf_waddr, 9);
        chk("force_wdata", rf_wdata, 32'h1234);
        settle;
        chk("post_force_stall", wb_stall, 0);
        tick;
        wb_we = 0;
        chk("held_wb_addr", rf_waddr, 10);
        chk("held_wb_data", rf_wdata, 32'hA4);
        tick;

        // Scoreboard
        mdu_issue = 1; mdu_issue_addr = 5'd5; rd_addr1 = 5'd5;
        settle;
        chk("sb_hazard_c0", hazard, 0);
        tick;
        mdu_issue = 0;
        settle;
        chk("sb_busy_c1", busy, 32'h20);
        chk("sb_hazard_c1", hazard, 1);
        rd_addr1 = 0; rd_addr2 = 5'd5;
        settle;
        chk("sb_hazard_rd2", hazard, 1);
        rd_addr1 = 5'd5; rd_addr2 = 0;
        tick;
        wb_we = 1; wb_addr = 5'd11; wb_data = 32'hB;
        mdu_valid = 1; mdu_addr = 5'd5; mdu_data = 32'h55;
        settle;
        chk("sb_denied_c2", mdu_ready, 0);
        tick;
        wb_we = 0;
        settle;
        chk("sb_grant_c3", mdu_ready, 1);
        tick;
        mdu_valid = 0;
        chk("sb_write_addr_c4", rf_waddr, 5);
        chk("sb_hazard_c4", hazard, 1);
        tick;
        chk("sb_busy_c5", busy, 0);
        chk("sb_hazard_c5", hazard, 0);
        rd_addr1 = 0;

        // Zero register
        wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
        mdu_valid = 1; mdu_addr = 5'd12; mdu_data = 32'hC0FFEE;
        settle;
        chk("zero_wb_mdu_ready", mdu_ready, 1);
        tick;
        wb_we = 0;
        mdu_addr = 0; mdu_data = 32'h77;
        chk("zero_rf_waddr", rf_waddr, 12);
        chk("zero_rf_wdata", rf_wdata, 32'hC0FFEE);
        settle;
        chk("zero_addr_ready", mdu_ready, 1);
        tick;
        mdu_valid = 0;
        chk("zero_addr_no_we", rf_we, 0);
        mdu_issue = 1; mdu_issue_addr = 0;
        tick;
        mdu_issue = 0;
        chk("zero_issue_busy", busy, 0);
        settle;
        chk("zero_rd_hazard", hazard, 0);

        // Set beats clear
        mdu_issue = 1; mdu_issue_addr = 5'd3;
        tick;
        mdu_issue = 0;
        mdu_valid = 1; mdu_addr = 5'd3; mdu_data = 32'h33;
        chk("sbc_busy_set", busy, 32'h8);
        tick;
        mdu_valid = 0;
        chk("sbc_port_addr", rf_waddr, 3);
        mdu_issue = 1; mdu_issue_addr = 5'd3;
        tick;
        mdu_issue = 0;
        chk("sbc_busy_after", busy, 32'h8);

        // Reset during FORCE
        wb_we = 1; wb_addr = 5'd13; wb_data = 32'hD;
        mdu_valid = 1; mdu_addr = 5'd14; mdu_data = 32'hE;
        repeat (4) tick;
        settle;
        chk("rst_pre_force", wb_stall, 1);
        rst = 1;
        #1;
        chk("rst_mid_stall", wb_stall, 0);
        chk("rst_mid_rf_we", rf_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", mdu_ready, 0);
        tick;
        wb_we = 0;
        rst = 0;
        settle;
        chk("rst_rel_ready", mdu_ready, 1);
        tick;
        mdu_valid = 0;
        chk("rst_rel_rf_we", rf_we, 1);
        chk("rst_rel_waddr", rf_waddr, 14);
        chk("rst_rel_wdata", rf_wdata, 32'hE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
